// File: rtl/n1_pkg.sv
// Shared definitions for the n1 accumulator core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n1_pkg;

    localparam int N1_ADDR_BITS = 6;

    // Opcode field is byte0[3:0]; C/D/E are unassigned and execute as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_M    = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // Opcodes that read data RAM and therefore need the extra M cycle.
    function automatic logic needs_mem(input logic [3:0] op);
        return (op == OP_LD) || ((op >= OP_ADD) && (op <= OP_XOR));
    endfunction

endpackage

// File: rtl/n1_if.sv
// Core-side bus of the n1 core: start, program/data RAM ports, status/debug.
// Latency: n/a (wiring only).
// Backpressure: none; RAMs answer with a fixed one-cycle registered read.
interface n1_if
    import n1_pkg::*;
#(
    parameter int ADDR_BITS = N1_ADDR_BITS
) ();
    logic                 start;
    logic [ADDR_BITS-1:0] pmem_addr;
    logic [7:0]           pmem_rdata;
    logic [ADDR_BITS-1:0] dmem_addr;
    logic                 dmem_we;
    logic [7:0]           dmem_wdata;
    logic [7:0]           dmem_rdata;
    logic                 busy;
    logic                 halted;
    logic                 retire;
    logic [7:0]           acc;
    logic [ADDR_BITS-1:0] pc;

    // Core side
    modport master (
        input  start, pmem_rdata, dmem_rdata,
        output pmem_addr, dmem_addr, dmem_we, dmem_wdata,
               busy, halted, retire, acc, pc
    );

    // RAM / loader / bench side
    modport slave (
        output start, pmem_rdata, dmem_rdata,
        input  pmem_addr, dmem_addr, dmem_we, dmem_wdata,
               busy, halted, retire, acc, pc
    );
endinterface

// File: rtl/n1_alu.sv
// Combinational ALU for the n1 core: result and Z/C for LDI/LD/ADD/SUB/AND/OR/XOR.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module n1_alu
    import n1_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] res_o,
    output logic       z_o,
    output logic       c_o
);

    logic [8:0] wide;

    // Result/carry per opcode; loads and logic ops pass the incoming carry through.
    always_comb begin
        wide  = 9'd0;
        res_o = a_i;
        c_o   = c_i;
        case (op_i)
            OP_LDI, OP_LD: res_o = b_i;
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res_o = wide[7:0];
                c_o   = wide[8];
            end
            OP_SUB: begin
                // Bit 8 of the 9-bit difference is set exactly when a < b (borrow).
                wide  = {1'b0, a_i} - {1'b0, b_i};
                res_o = wide[7:0];
                c_o   = wide[8];
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            default: ;
        endcase
        z_o = (res_o == 8'h00);
    end

endmodule

// File: rtl/n1_core.sv
// 8-bit accumulator core: fetches 2-byte instructions, executes against data RAM, keeps ACC/Z/C.
// Latency: 3 cycles per instruction (F0,F1,F2), 4 for LD/ALU ops (extra M cycle).
// Backpressure: none; start is ignored while busy, RAM reads are fixed 1-cycle.
module n1_core
    import n1_pkg::*;
#(
    parameter int ADDR_BITS = N1_ADDR_BITS
) (
    input  logic clk,
    input  logic rst,
    n1_if.master core_bus
);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] pc_q, pc_d;
    logic [7:0]           acc_q, acc_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic [3:0]           opcode_q, opcode_d;

    logic [ADDR_BITS-1:0] operand;
    logic                 jump_taken;
    logic [7:0]           alu_b;
    logic [7:0]           alu_res;
    logic                 alu_z;
    logic                 alu_c;

    // In F2 the program RAM is presenting byte1 (addressed in F1); use it directly.
    assign operand    = core_bus.pmem_rdata[ADDR_BITS-1:0];
    assign jump_taken = (opcode_q == OP_JMP) ||
                        ((opcode_q == OP_JZ) && z_q) ||
                        ((opcode_q == OP_JC) && c_q);
    // LDI takes its immediate in F2; memory ops take the RAM word in M.
    assign alu_b      = (state_q == S_M) ? core_bus.dmem_rdata : core_bus.pmem_rdata;

    n1_alu u_alu (
        .op_i  (opcode_q),
        .a_i   (acc_q),
        .b_i   (alu_b),
        .c_i   (c_q),
        .res_o (alu_res),
        .z_o   (alu_z),
        .c_o   (alu_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (core_bus.start) state_d = S_F0;
            S_F0:           state_d = S_F1;
            S_F1:           state_d = S_F2;
            S_F2: begin
                if (needs_mem(opcode_q))      state_d = S_M;
                else if (opcode_q == OP_HLT)  state_d = S_HALT;
                else                          state_d = S_F0;
            end
            S_M:            state_d = S_F0;
            default:        state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; anything not driven in a state stays 0
    always_comb begin
        core_bus.pmem_addr  = '0;
        core_bus.dmem_addr  = '0;
        core_bus.dmem_we    = 1'b0;
        core_bus.dmem_wdata = 8'h00;
        core_bus.retire     = 1'b0;
        core_bus.busy       = 1'b0;
        core_bus.halted     = 1'b0;
        case (state_q)
            S_F0: begin
                core_bus.busy      = 1'b1;
                core_bus.pmem_addr = pc_q;
            end
            S_F1: begin
                core_bus.busy      = 1'b1;
                core_bus.pmem_addr = pc_q + ADDR_BITS'(1);
            end
            S_F2: begin
                core_bus.busy   = 1'b1;
                core_bus.retire = !needs_mem(opcode_q);
                if (needs_mem(opcode_q) || (opcode_q == OP_ST))
                    core_bus.dmem_addr = operand;
                if (opcode_q == OP_ST) begin
                    core_bus.dmem_we    = 1'b1;
                    core_bus.dmem_wdata = acc_q;
                end
            end
            S_M: begin
                core_bus.busy   = 1'b1;
                core_bus.retire = 1'b1;
            end
            S_HALT:  core_bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign core_bus.acc = acc_q;
    assign core_bus.pc  = pc_q;

    // Datapath next values: PC sequencing, opcode capture, ACC/flag writeback
    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE, S_HALT: if (core_bus.start) pc_d = '0;
            S_F1: opcode_d = core_bus.pmem_rdata[3:0];
            S_F2: begin
                pc_d = jump_taken ? operand : (pc_q + ADDR_BITS'(2));
                if (opcode_q == OP_LDI) begin
                    acc_d = alu_res;
                    z_d   = alu_z;
                    c_d   = alu_c;
                end
            end
            S_M: begin
                acc_d = alu_res;
                z_d   = alu_z;
                c_d   = alu_c;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            acc_q    <= 8'h00;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            opcode_q <= 4'h0;
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            opcode_q <= opcode_d;
        end
    end

endmodule
